// File: rtl/tmds_serializer.sv
// TMDS transmit serializer: takes pre-encoded 10-bit words for three data lanes,
// shifts them out LSB first at bit rate, and drives the 5-high/5-low TMDS clock lane.
module tmds_serializer #(
    parameter logic [9:0] IDLE_D0     = 10'b1010101011,
    parameter logic [9:0] IDLE_D12    = 10'b1101010100,
    parameter logic [9:0] CLK_PATTERN = 10'b0000011111,
    parameter int         UNDERRUN_W  = 16
) (
    input  logic                  bit_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [9:0]            d0,
    input  logic [9:0]            d1,
    input  logic [9:0]            d2,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_d0,
    output logic                  out_d1,
    output logic                  out_d2,
    output logic                  out_clk,
    output logic                  word_start,
    output logic                  running,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [UNDERRUN_W-1:0] UNDERRUN_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};

    logic [0:0]            state_q, state_d;
    logic [3:0]            phase_q, phase_d;
    logic [9:0]            sh0_q, sh0_d;
    logic [9:0]            sh1_q, sh1_d;
    logic [9:0]            sh2_q, sh2_d;
    logic [9:0]            shc_q, shc_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    logic                  last_phase;

    // Handshake: a word is taken at the rising edge where in_ready && in_valid; in_ready
    // is only ever high in the final bit slot of a RUN word period with enable high.
    assign last_phase = (phase_q == 4'd9);
    assign running    = (state_q == S_RUN);
    assign in_ready   = running && last_phase && enable;
    assign word_start = running && (phase_q == 4'd0);

    assign out_d0         = sh0_q[0];
    assign out_d1         = sh1_q[0];
    assign out_d2         = sh2_q[0];
    assign out_clk        = shc_q[0];
    assign underrun_count = underrun_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        shc_d      = shc_q;
        underrun_d = underrun_q;
        case (state_q)
            S_IDLE: begin
                // Enter on the last slot so the first load happens one edge later.
                if (enable) begin
                    state_d = S_RUN;
                    phase_d = 4'd9;
                end
            end
            S_RUN: begin
                if (last_phase) begin
                    if (enable) begin
                        phase_d = 4'd0;
                        shc_d   = CLK_PATTERN;
                        if (in_valid) begin
                            sh0_d = d0;
                            sh1_d = d1;
                            sh2_d = d2;
                        end else begin
                            sh0_d = IDLE_D0;
                            sh1_d = IDLE_D12;
                            sh2_d = IDLE_D12;
                            if (underrun_q != {UNDERRUN_W{1'b1}}) begin
                                underrun_d = underrun_q + UNDERRUN_ONE;
                            end
                        end
                    end else begin
                        state_d = S_IDLE;
                        phase_d = 4'd0;
                        sh0_d   = '0;
                        sh1_d   = '0;
                        sh2_d   = '0;
                        shc_d   = '0;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                    sh0_d   = {1'b0, sh0_q[9:1]};
                    sh1_d   = {1'b0, sh1_q[9:1]};
                    sh2_d   = {1'b0, sh2_q[9:1]};
                    shc_d   = {1'b0, shc_q[9:1]};
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge bit_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            phase_q    <= 4'd0;
            sh0_q      <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            shc_q      <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            shc_q      <= shc_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_tmds_serializer.sv
// Bench for tmds_serializer: per-cycle lane scoreboard fed at each accepted word slot,
// plus a small protocol model for in_ready, running and the underrun counter.
module tb_tmds_serializer;

    localparam int UW = 5;
    localparam logic [9:0] P_IDLE_D0  = 10'b1010101011;
    localparam logic [9:0] P_IDLE_D12 = 10'b1101010100;
    localparam logic [9:0] P_CLK_PAT  = 10'b0000011111;

    logic          bit_clk;
    logic          reset_n;
    logic          enable;
    logic [9:0]    d0, d1, d2;
    logic          in_valid;
    logic          in_ready;
    logic          out_d0, out_d1, out_d2, out_clk;
    logic          word_start;
    logic          running;
    logic [UW-1:0] underrun_count;

    tmds_serializer #(
        .IDLE_D0     (P_IDLE_D0),
        .IDLE_D12    (P_IDLE_D12),
        .CLK_PATTERN (P_CLK_PAT),
        .UNDERRUN_W  (UW)
    ) dut (
        .bit_clk        (bit_clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .d0             (d0),
        .d1             (d1),
        .d2             (d2),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_d0         (out_d0),
        .out_d1         (out_d1),
        .out_d2         (out_d2),
        .out_clk        (out_clk),
        .word_start     (word_start),
        .running        (running),
        .underrun_count (underrun_count)
    );

    // clock / reset
    initial bit_clk = 1'b0;
    always #5 bit_clk = ~bit_clk;

    int n_cmp = 0;
    int n_err = 0;

    // {word_start, out_clk, out_d2, out_d1, out_d0} expected per cycle
    logic [4:0]  exp_q[$];
    logic [29:0] wq[$];

    logic          m_run;
    logic [3:0]    m_phase;
    logic [UW-1:0] m_under;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2);
        logic [9:0] pat;
        pat = P_CLK_PAT;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({(k == 0), pat[k], w2[k], w1[k], w0[k]});
        end
    endtask

    // One bit period: check outputs, drive inputs, update the model, advance.
    task automatic step(input logic en, input logic starve);
        logic [4:0]  obs;
        logic [4:0]  exp;
        logic        exp_rdy;
        logic        vld;
        logic [29:0] w;
        obs = {word_start, out_clk, out_d2, out_d1, out_d0};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b0;
        check_val("lanes", {27'd0, obs}, {27'd0, exp});
        check_val("running", {31'd0, running}, {31'd0, m_run});
        check_val("underrun", {{(32-UW){1'b0}}, underrun_count}, {{(32-UW){1'b0}}, m_under});
        exp_rdy = m_run && (m_phase == 4'd9) && en;
        vld     = !starve && (wq.size() > 0);
        w       = vld ? wq[0] : 30'($urandom());
        enable  = en;
        in_valid = exp_rdy ? vld : 1'($urandom_range(0, 1));
        d0 = w[9:0];
        d1 = w[19:10];
        d2 = w[29:20];
        #1;
        check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) begin
            if (vld) begin
                void'(wq.pop_front());
                push_word(w[9:0], w[19:10], w[29:20]);
            end else begin
                push_word(P_IDLE_D0, P_IDLE_D12, P_IDLE_D12);
                if (m_under != {UW{1'b1}}) m_under = m_under + 1'b1;
            end
        end
        if (!m_run) begin
            if (en) begin
                m_run   = 1'b1;
                m_phase = 4'd9;
            end
        end else if (m_phase == 4'd9) begin
            if (en) m_phase = 4'd0;
            else begin
                m_run   = 1'b0;
                m_phase = 4'd0;
            end
        end else begin
            m_phase = m_phase + 4'd1;
        end
        @(negedge bit_clk);
    endtask

    task automatic seek_phase(input logic [3:0] ph);
        for (int i = 0; i < 20; i++) begin
            if (m_run && m_phase == ph) break;
            step(1'b1, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {24'd0, in_ready, out_d0, out_d1, out_d2, out_clk, word_start, running,
                        |underrun_count}, 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        m_run = 1'b0; m_phase = 4'd0; m_under = '0;
        repeat (3) @(negedge bit_clk);
        enable = 1'b1;
        in_valid = 1'b1;
        #1;
        check_all_zero("reset_outputs");
        @(negedge bit_clk);
        reset_n = 1'b1;
        enable  = 1'b0;

        // single word 2AB on d0, then 000/3FF/155 on d1 back to back
        wq.push_back({10'h000, 10'h000, 10'h2AB});
        wq.push_back({10'h0F0, 10'h000, 10'h12C});
        wq.push_back({10'h3C3, 10'h3FF, 10'h001});
        wq.push_back({10'h200, 10'h155, 10'h3FE});
        for (int i = 0; i < 41; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        check_val("underrun_eq3", {{(32-UW){1'b0}}, underrun_count}, 32'd3);

        // enable dropped at phase 4: word completes, then idle with no in_ready
        for (int i = 0; i < 4; i++) wq.push_back(30'($urandom()));
        seek_phase(4'd4);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        check_val("stopped", {31'd0, running}, 32'd0);
        for (int i = 0; i < 35; i++) step(1'b1, 1'b0);

        // saturate the (narrowed) underrun counter
        for (int i = 0; i < 340; i++) step(1'b1, 1'b1);
        check_val("underrun_sat", {{(32-UW){1'b0}}, underrun_count}, {{(32-UW){1'b0}}, {UW{1'b1}}});

        // random enable pulses, starvation and data
        for (int i = 0; i < 400; i++) begin
            if (wq.size() < 2) wq.push_back(30'($urandom()));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
        end

        // asynchronous reset in the middle of a word
        for (int i = 0; i < 3; i++) wq.push_back(30'($urandom()));
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        seek_phase(4'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        wq.delete();
        m_run = 1'b0; m_phase = 4'd0; m_under = '0;
        enable = 1'b0;
        @(negedge bit_clk);
        reset_n = 1'b1;
        wq.push_back({10'h155, 10'h2AA, 10'h0FF});
        wq.push_back({10'h3FF, 10'h000, 10'h2AB});
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
